mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Memory-stage load/store sequencer between the M-stage datapath and a word-wide data memory with req/ready handshake.
//  Converts byte/half/word accesses at any byte address into one or two aligned word accesses.
//  Generates byte enables and stalls the pipeline until the access completes.
//  Loads return byte-aligned raw data (LSB at bit 0); the downstream partial-word extender sign/zero-extends it.
// PARAMETERS
//  DATA_WIDTH        32  data/address width; only 32 is supported (4 byte lanes)
//  ALLOW_MISALIGNED  1   1: split accesses that cross a word; 0: raise FaultM and make no memory access
// PORTS
//  clk              in   1   clock, all state updates on rising edge
//  reset            in   1   synchronous, active-high
//  MemReqM          in   1   M-stage access valid; held stable while StallM=1
//  MemWriteM        in   1   1=store, 0=load
//  SizeM            in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  AddrM            in   32  byte address
//  WriteDataM       in   32  store data, LSB-aligned
//  StallM           out  1   hold pipeline
//  DoneM            out  1   1-cycle pulse: access complete, ReadDataAlignedM valid
//  FaultM           out  1   1-cycle pulse: illegal size or disallowed misalignment
//  ReadDataAlignedM out  32  load bytes shifted down to bit 0; bits above the access size are don't-care
//  dmem_req         out  1   memory request
//  dmem_we          out  1   write enable
//  dmem_addr        out  32  word-aligned address ([1:0]=0)
//  dmem_be          out  4   byte enables; stores only
//  dmem_wdata       out  32  lane-positioned store data
//  dmem_ready       in   1   memory accepts/completes the current beat this cycle
//  dmem_rdata       in   32  read data, valid in the cycle dmem_ready=1
// BEHAVIOUR
//  Clocking and reset
//   - One clock (clk); reset is synchronous and active-high.
//   - Reset values: state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, DoneM=0, FaultM=0, ReadDataAlignedM=0.
//  States: IDLE, ACC1, ACC2, DONE
//   - IDLE: when MemReqM=1, latch the request (off=AddrM[1:0], n=1/2/4 from SizeM).
//     - split = off+n>4.
//     - Illegal request goes to FAULT (FaultM=1 next cycle), then IDLE. Illegal = SizeM not in table, a store with size 100/101,
//       or split with ALLOW_MISALIGNED=0.
//     - Otherwise go to ACC1.
//   - ACC1: dmem_req=1, dmem_addr={AddrM[31:2],2'b00}. Hold all memory outputs stable until dmem_ready.
//     - On ready, capture rdata into lo; go to ACC2 if split, else DONE.
//   - ACC2: dmem_req=1, dmem_addr=first+4, wrapping at 2^32. On ready, capture rdata into hi; go to DONE.
//   - DONE: DoneM=1, StallM=0, pipeline advances; next state IDLE.
//   - FAULT is a one-cycle state: FaultM=1, StallM=0.
//  Stall and latency
//   - StallM = MemReqM & (state!=DONE) & (state!=FAULT).
//   - Combinational from MemReqM in IDLE, so the instruction is held from its first M cycle.
//   - Latency with ready held high: 3 cycles non-split, 4 cycles split.
//   - A back-to-back request is accepted in the IDLE cycle after DONE.
//  Byte lanes
//   - Load: ReadDataAlignedM = ({hi,lo} >> 8*off)[31:0]; hi=0 when not split.
//   - Store: mask8 = ((1<<n)-1) << off; wd64 = {32'b0,WriteDataM} << 8*off.
//     - ACC1 drives be=mask8[3:0], wdata=wd64[31:0].
//     - ACC2 drives be=mask8[7:4], wdata=wd64[63:32].
//   - Loads drive dmem_be=0 and dmem_we=0.
//  Boundary conditions
//   - dmem_ready is ignored outside ACC1/ACC2.
//   - MemReqM dropping mid-access (flush): the access still completes; DoneM still pulses.
//   - reset mid-access: IDLE on the same edge, dmem_req=0 next cycle; no retry, the in-flight beat is abandoned.
//   - ReadDataAlignedM holds its value until the next DONE.
// STRUCTURE
//  - Package mem_ctrl_pkg: typedef enum state_t {IDLE,ACC1,ACC2,DONE,FAULT}; size codes SZ_B..SZ_HU; function size_bytes(funct3).
//  - Sub-module byte_lane_align: combinational; computes mask8, wd64, split, legal and load shift from off, size and data.
//  - The FSM and the capture registers stay in mem_access_ctrl.
// TESTING
//  - LW at 0x100, ready=1: ACC1 addr=0x100, rdata=0xDEADBEEF -> ReadDataAlignedM=0xDEADBEEF, DoneM on cycle 3, StallM high for cycles 1-2.
//  - LB at 0x103, rdata=0x80112233 -> ReadDataAlignedM[7:0]=0x80, one access, be=0.
//  - SH at 0x102, data 0x0000ABCD -> one beat: addr=0x100, be=1100, wdata=0xABCD0000.
//  - SW at 0x203, ALLOW_MISALIGNED=1, data 0x11223344:
//    - beat 1: addr=0x200, be=1000, wdata=0x44000000.
//    - beat 2: addr=0x204, be=0111, wdata=0x00112233.
//  - LW at 0x1FE, rdata lo=0xAABBCCDD, hi=0x11223344, ready low 2 cycles per beat -> ReadDataAlignedM=0x3344AABB; dmem outputs stable while waiting.
//  - Reset asserted in ACC1 with ready=0 -> IDLE next cycle, dmem_req=0; store with SizeM=100 -> FaultM pulse, no dmem_req.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory-stage load/store sequencer.
//   state_t    : sequencer states
//   SZ_*       : funct3 size codes
//   size_bytes : access width in bytes for a funct3 code, 0 for illegal codes
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACC1,
    ACC2,
    DONE,
    FAULT
  } state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      SZ_B, SZ_BU: return 3'd1;
      SZ_H, SZ_HU: return 3'd2;
      SZ_W:        return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational byte-lane steering for one load/store request.
//   off, size, is_store, wdata : request byte offset, funct3, direction, LSB-aligned store data
//   lo, hi                     : first and second memory words of a load (hi=0 when not split)
//   mask8                      : 8-lane byte mask spanning both words
//   wd64                       : store data positioned across both words
//   split                      : request crosses into the next word
//   legal                      : request can be performed
//   rdata_aligned              : load bytes shifted down to bit 0
module byte_lane_align
  import mem_ctrl_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [7:0]  mask8,
  output logic [63:0] wd64,
  output logic        split,
  output logic        legal,
  output logic [31:0] rdata_aligned
);

  logic [2:0] n;
  logic [3:0] span;
  logic [5:0] shamt;

  always_comb begin
    n     = size_bytes(size);
    span  = {1'b0, n} + {2'b00, off};
    split = span > 4'd4;
    // Unsigned variants have no store form.
    legal = (n != 3'd0) && !(is_store && size[2]) && (ALLOW_MISALIGNED || !split);
    shamt = {1'b0, off, 3'b000};
    mask8 = ((8'd1 << n) - 8'd1) << off;
    wd64  = {32'd0, wdata} << shamt;
    rdata_aligned = 32'({hi, lo} >> shamt);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer. Turns a byte/half/word access at any
// byte address into one or two aligned word beats on a req/ready memory port
// and stalls the pipeline until the access completes.
//   clk, reset                  : clock, synchronous active-high reset
//   MemReqM, MemWriteM          : access valid, 1=store
//   SizeM, AddrM, WriteDataM    : funct3 size, byte address, LSB-aligned store data
//   StallM, DoneM, FaultM       : hold pipeline, completion pulse, illegal-access pulse
//   ReadDataAlignedM            : load bytes shifted to bit 0, held until the next completion
//   dmem_req/we/addr/be/wdata   : memory request (registered, stable until dmem_ready)
//   dmem_ready, dmem_rdata      : memory beat accept and read data
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemReqM,
  input  logic                  MemWriteM,
  input  logic [2:0]            SizeM,
  input  logic [DATA_WIDTH-1:0] AddrM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  StallM,
  output logic                  DoneM,
  output logic                  FaultM,
  output logic [DATA_WIDTH-1:0] ReadDataAlignedM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;

  logic [1:0]  off_s;
  logic [2:0]  size_s;
  logic        store_s;
  logic [31:0] wdata_s;
  logic [31:0] lo_s;
  logic [31:0] hi_s;

  logic [7:0]  mask8;
  logic [63:0] wd64;
  logic        split;
  logic        legal;
  logic [31:0] rdata_aligned;

  // One aligner serves both phases: in IDLE it sees the live request to
  // decide legality and the first beat; afterwards it sees the latched copy,
  // so a flushed (changing) M-stage request cannot disturb an access in flight.
  always_comb begin
    off_s   = (state == IDLE) ? AddrM[1:0] : off_q;
    size_s  = (state == IDLE) ? SizeM      : size_q;
    store_s = (state == IDLE) ? MemWriteM  : we_q;
    wdata_s = (state == IDLE) ? WriteDataM : wdata_q;
    lo_s    = (state == ACC2) ? lo_q       : dmem_rdata;
    hi_s    = (state == ACC2) ? dmem_rdata : '0;
    StallM  = MemReqM && (state != DONE) && (state != FAULT);
  end

  byte_lane_align #(
    .ALLOW_MISALIGNED(ALLOW_MISALIGNED)
  ) u_align (
    .off          (off_s),
    .size         (size_s),
    .is_store     (store_s),
    .wdata        (wdata_s),
    .lo           (lo_s),
    .hi           (hi_s),
    .mask8        (mask8),
    .wd64         (wd64),
    .split        (split),
    .legal        (legal),
    .rdata_aligned(rdata_aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      off_q            <= '0;
      size_q           <= '0;
      we_q             <= 1'b0;
      wdata_q          <= '0;
      lo_q             <= '0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_be          <= '0;
      dmem_wdata       <= '0;
      DoneM            <= 1'b0;
      FaultM           <= 1'b0;
      ReadDataAlignedM <= '0;
    end else begin
      DoneM  <= 1'b0;
      FaultM <= 1'b0;
      case (state)
        IDLE: begin
          if (MemReqM) begin
            off_q   <= AddrM[1:0];
            size_q  <= SizeM;
            we_q    <= MemWriteM;
            wdata_q <= WriteDataM;
            if (!legal) begin
              state  <= FAULT;
              FaultM <= 1'b1;
            end else begin
              state      <= ACC1;
              dmem_req   <= 1'b1;
              dmem_we    <= MemWriteM;
              dmem_addr  <= {AddrM[DATA_WIDTH-1:2], 2'b00};
              dmem_be    <= MemWriteM ? mask8[3:0] : 4'b0000;
              dmem_wdata <= wd64[31:0];
            end
          end
        end
        ACC1: begin
          if (dmem_ready) begin
            lo_q <= dmem_rdata;
            if (split) begin
              state      <= ACC2;
              dmem_addr  <= dmem_addr + 32'd4;
              dmem_be    <= we_q ? mask8[7:4] : 4'b0000;
              dmem_wdata <= wd64[63:32];
            end else begin
              state    <= DONE;
              DoneM    <= 1'b1;
              dmem_req <= 1'b0;
              dmem_we  <= 1'b0;
              dmem_be  <= '0;
              if (!we_q) ReadDataAlignedM <= rdata_aligned;
            end
          end
        end
        ACC2: begin
          if (dmem_ready) begin
            state    <= DONE;
            DoneM    <= 1'b1;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= '0;
            if (!we_q) ReadDataAlignedM <= rdata_aligned;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
